aes_byte_loader: RTL and testbench
==================================

AES_BYTE_LOADER -- requirements
Module: aes_byte_loader

Interface
REQ-001 The module SHALL expose ports in this order: clk, rst, clear, byte_in, byte_valid, byte_ready, state_out, state_valid, state_ready, byte_count.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort; discards partial or held block.
- byte_in  input  8  serial input byte.
- byte_valid  input  1  byte_in valid this cycle.
- byte_ready  output  1  loader can accept a byte this cycle.
- state_out  output  128  assembled AES state, column-major.
- state_valid  output  1  state_out holds a complete 16-byte block.
- state_ready  input  1  downstream consumes the block this cycle.
- byte_count  output  5  bytes held, 0..16.
REQ-002 The module SHALL have one clock (clk); reset (rst) SHALL be synchronous and active-high. Polarity and synchronicity are fixed.
REQ-003 The module SHALL have no parameters; widths are fixed at 8-bit bytes and a 128-bit state.

Function
REQ-004 The module SHALL implement a two-state FSM: LOAD and HOLD.
REQ-005 In LOAD, byte_ready SHALL be 1 and state_valid SHALL be 0.
REQ-006 In HOLD, byte_ready SHALL be 0 and state_valid SHALL be 1.
REQ-007 A byte SHALL be accepted only when byte_valid && byte_ready && !clear at a rising edge.
REQ-008 A 4-bit write index idx SHALL select the destination byte: column = idx[3:2], row = idx[1:0]. This is the inverse of the 4:1 row-select byte mux.
REQ-009 An accepted byte SHALL be written to state_out[127-8*idx -: 8], so the first byte lands in the MSB (FIPS-197 input ordering). All other bytes SHALL be unchanged.
REQ-010 idx SHALL increment by 1 on each accepted byte, wrapping 15->0.
REQ-011 byte_count SHALL equal the number of bytes accepted in the current block: 0..15 in LOAD, 16 in HOLD.
REQ-012 Acceptance of the 16th byte (idx=15) SHALL move the FSM to HOLD at that edge. state_valid SHALL be 1 in the following cycle; latency is one cycle from last byte to valid.
REQ-013 In HOLD, state_out SHALL remain stable until the block is consumed.
REQ-014 In HOLD, state_ready=1 at an edge SHALL return the FSM to LOAD with idx=0 and byte_count=0. state_out SHALL retain the last block; it is not cleared.
REQ-015 No byte SHALL be accepted in the cycle the block is consumed; byte_ready rises the cycle after.
REQ-016 state_ready SHALL be ignored in LOAD.
REQ-017 clear=1 at an edge SHALL force LOAD with idx=0 and byte_count=0 from either state. state_out SHALL be unchanged.
REQ-018 clear SHALL take priority over a simultaneous byte_valid, which is dropped, and over a simultaneous state_ready.
REQ-019 byte_valid while byte_ready=0 SHALL have no effect, and no byte SHALL be stored.

Reset
REQ-020 rst=1 at an edge SHALL set: FSM=LOAD, idx=0, byte_count=0, state_out=128'h0, state_valid=0, byte_ready=1.
REQ-021 rst SHALL take priority over clear, byte_valid and state_ready.
REQ-022 rst asserted mid-block or in HOLD SHALL discard all data and zero state_out.

Verification
REQ-023 Full load: after reset, feed bytes 00,11,22,...,ff on 16 consecutive cycles -> state_valid=1 one cycle after the last byte; state_out=128'h00112233445566778899aabbccddeeff; byte_count=16.
REQ-024 Backpressure: hold state_ready=0 for 5 cycles in HOLD while byte_valid=1 with byte_in=AA -> state_out unchanged; byte_ready=0; then state_ready=1 -> next cycle byte_ready=1, byte_count=0.
REQ-025 Gapped input: 16 bytes with byte_valid toggling 1/0 each cycle -> same state_out as REQ-023; state_valid rises 1 cycle after the 16th accepted byte.
REQ-026 Abort: accept 7 bytes, then clear=1 together with byte_valid=1 -> byte_count=0; the dropped byte is not written; the next 16 bytes form a correct block at idx 0..15.
REQ-027 Reset mid-operation: rst=1 in HOLD with state_ready=1 and clear=1 -> next cycle state_out=0, state_valid=0, byte_ready=1, byte_count=0.
REQ-028 Back-to-back blocks: two blocks with state_ready tied to 1 -> exactly one bubble cycle between the 16th byte and the first byte of block 2; block 2 bytes overwrite every lane.

Source files
------------

// File: rtl/aes_byte_loader.sv
// Serial byte loader for a 128-bit AES state: collects 16 bytes in FIPS-197 input
// order (first byte in the MSB) and holds the block until downstream consumes it.
module aes_byte_loader (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  output logic [127:0] state_out,
  output logic         state_valid,
  input  logic         state_ready,
  output logic [4:0]   byte_count
);

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [3:0]   idx_q;
  logic [3:0]   idx_d;
  logic [127:0] data_d;
  logic         accept;

  always_comb begin
    byte_ready  = (state_q == LOAD);
    state_valid = (state_q == HOLD);
    // idx wraps to 0 on the 16th byte, so HOLD reports the full count explicitly
    byte_count  = (state_q == HOLD) ? 5'd16 : {1'b0, idx_q};
    accept      = byte_valid & byte_ready & ~clear;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (clear) begin
      state_d = LOAD;
      idx_d   = 4'd0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) state_d = HOLD;
          end
        end
        HOLD: begin
          if (state_ready) begin
            state_d = LOAD;
            idx_d   = 4'd0;
          end
        end
        default: begin
          state_d = LOAD;
          idx_d   = 4'd0;
        end
      endcase
    end
  end

  // Write demux: column idx[3:2], row idx[1:0]; lane 0 is the MSB byte
  always_comb begin
    data_d = state_out;
    for (int i = 0; i < 16; i++) begin
      if (accept && (idx_q == 4'(i))) data_d[8*(15-i) +: 8] = byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      idx_q     <= 4'd0;
      state_out <= 128'h0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      state_out <= data_d;
    end
  end

endmodule

// File: tb/tb_aes_byte_loader.sv
// Bench for aes_byte_loader: a byte-array model checked every cycle, plus directed
// scenarios with literal expected blocks.
module tb_aes_byte_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic [7:0]   byte_in = 8'h00;
  logic         byte_valid = 1'b0;
  logic         byte_ready;
  logic [127:0] state_out;
  logic         state_valid;
  logic         state_ready = 1'b0;
  logic [4:0]   byte_count;

  int n_cmp = 0;
  int n_bad = 0;

  aes_byte_loader dut (
    .clk(clk), .rst(rst), .clear(clear), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .state_out(state_out),
    .state_valid(state_valid), .state_ready(state_ready), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a block is an ordered list of 16 bytes, the first byte shown leftmost
  logic [7:0] mb [16];
  int         mcnt = 0;
  bit         mhold = 1'b0;
  bit         chk_en = 1'b0;

  function automatic logic [127:0] model_block();
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], mb[i]};
    return v;
  endfunction

  always @(posedge clk) begin
    logic s_rst, s_clr, s_bv, s_sr;
    logic [7:0] s_b;
    s_rst = rst; s_clr = clear; s_bv = byte_valid; s_sr = state_ready; s_b = byte_in;
    if (s_rst === 1'b1) begin
      for (int i = 0; i < 16; i++) mb[i] = 8'h00;
      mcnt = 0;
      mhold = 1'b0;
      chk_en = 1'b1;
    end else if (s_clr) begin
      mcnt = 0;
      mhold = 1'b0;
    end else if (mhold) begin
      if (s_sr) begin
        mhold = 1'b0;
        mcnt = 0;
      end
    end else if (s_bv) begin
      mb[mcnt] = s_b;
      mcnt++;
      if (mcnt == 16) mhold = 1'b1;
    end
    #1;
    if (chk_en) begin
      chk("model state_out", state_out, model_block());
      chk("model state_valid", 128'(state_valid), 128'(mhold));
      chk("model byte_ready", 128'(byte_ready), 128'(!mhold));
      chk("model byte_count", 128'(byte_count), mhold ? 128'd16 : 128'(mcnt));
    end
  end

  task automatic cyc(input logic r, input logic c, input logic bv, input logic [7:0] b,
                     input logic sr);
    @(negedge clk);
    rst = r; clear = c; byte_valid = bv; byte_in = b; state_ready = sr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] b;
    // Reset
    cyc(1, 0, 0, 8'h00, 0);
    chk("reset state_out", state_out, 128'h0);
    chk("reset byte_ready", 128'(byte_ready), 128'd1);
    chk("reset state_valid", 128'(state_valid), 128'd0);
    chk("reset byte_count", 128'(byte_count), 128'd0);

    // Full load 00,11,...,ff
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 8'h11);
      cyc(0, 0, 1, b, 0);
    end
    chk("full state_valid", 128'(state_valid), 128'd1);
    chk("full state_out", state_out, 128'h00112233445566778899aabbccddeeff);
    chk("full byte_count", 128'(byte_count), 128'd16);

    // Backpressure while HOLD
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'hAA, 0);
    chk("bp state_out", state_out, 128'h00112233445566778899aabbccddeeff);
    chk("bp byte_ready", 128'(byte_ready), 128'd0);
    cyc(0, 0, 1, 8'hAA, 1);
    chk("consume byte_ready", 128'(byte_ready), 128'd1);
    chk("consume byte_count", 128'(byte_count), 128'd0);
    chk("consume state_out kept", state_out, 128'h00112233445566778899aabbccddeeff);

    // Abort after 7 bytes with a simultaneous byte
    for (int i = 0; i < 7; i++) begin
      b = 8'(8'hA0 + i);
      cyc(0, 0, 1, b, 0);
    end
    chk("abort pre count", 128'(byte_count), 128'd7);
    cyc(0, 1, 1, 8'hEE, 1);
    chk("abort byte_count", 128'(byte_count), 128'd0);
    chk("abort state_out", state_out, 128'ha0a1a2a3a4a5a6778899aabbccddeeff);
    for (int i = 0; i < 16; i++) begin
      b = ~8'(i * 8'h11);
      cyc(0, 0, 1, b, 0);
    end
    chk("abort reload valid", 128'(state_valid), 128'd1);
    chk("abort reload block", state_out, 128'hffeeddccbbaa99887766554433221100);
    cyc(0, 0, 0, 8'h00, 1);

    // Gapped input
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 8'h11);
      cyc(0, 0, 1, b, 0);
      if (i < 15) cyc(0, 0, 0, 8'h5A, 0);
    end
    chk("gap state_valid", 128'(state_valid), 128'd1);
    chk("gap state_out", state_out, 128'h00112233445566778899aabbccddeeff);

    // Back-to-back with state_ready tied high: first edge consumes the held block
    cyc(0, 0, 1, 8'h77, 1);
    for (int j = 0; j < 33; j++) begin
      if (j < 16) b = 8'(j * 8'h11);
      else if (j == 16) b = 8'h99;
      else b = ~8'((j - 17) * 8'h11);
      cyc(0, 0, 1, b, 1);
      if (j == 15) chk("b2b block1", state_out, 128'h00112233445566778899aabbccddeeff);
      if (j == 16) chk("b2b bubble ready", 128'(byte_ready), 128'd1);
    end
    chk("b2b block2 valid", 128'(state_valid), 128'd1);
    chk("b2b block2", state_out, 128'hffeeddccbbaa99887766554433221100);

    // Reset in HOLD with state_ready and clear
    cyc(1, 1, 1, 8'h55, 1);
    chk("rst hold state_out", state_out, 128'h0);
    chk("rst hold state_valid", 128'(state_valid), 128'd0);
    chk("rst hold byte_ready", 128'(byte_ready), 128'd1);
    chk("rst hold byte_count", 128'(byte_count), 128'd0);

    // Reset mid-block
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'h3C, 0);
    chk("mid count", 128'(byte_count), 128'd5);
    cyc(1, 0, 1, 8'h3C, 0);
    chk("mid rst state_out", state_out, 128'h0);
    chk("mid rst count", 128'(byte_count), 128'd0);
    cyc(0, 0, 0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
